// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl
// Central stall/flush sequencer for the five-stage pipeline. It drives the
// PC, IF/ID, ID/EX, EX/MEM and MEM/WB load enables and the IF/ID and ID/EX
// flush strobes. It resolves load-use hazards and taken branches. It freezes
// the whole pipeline while a data-memory access waits for its ack, and traps
// to a sticky error state if the ack does not come within TIMEOUT cycles.
//
// Parameters:
//   TIMEOUT      max MEM_WAIT cycles without ack before trapping (2..255)
// Ports:
//   clk          clock, rising edge
//   rst_n        synchronous active-low reset
//   id_rs/id_rt  source registers of the instruction in ID
//   ex_rd        destination register of the instruction in EX
//   ex_mem_read  instruction in EX is a load
//   branch_taken branch resolved taken in EX this cycle
//   mem_access   instruction in MEM accesses data memory
//   dmem_ack     data memory completes the access this cycle
//   dmem_req     data-memory request
//   *_en         stage register load enables
//   *_flush      load a bubble into IF/ID or ID/EX
//   stall_cnt    cycles with pc_en low in RUN/MEM_WAIT, saturating
//                (only when PIPE_CTRL_PERF_EN is defined)
//   bus_err      sticky memory-timeout flag
//
// Build option: define PIPE_CTRL_PERF_EN to add the stall_cnt output.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// INIT     | one cycle after reset; pipeline held and flushed
// RUN      | normal issue; hazard rules and memory-request detection
// MEM_WAIT | pipeline frozen until dmem_ack; wait_cnt counts unacked cycles
// ERR      | memory timeout trap; everything held, bus_err set until reset

module pipeline_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        branch_taken,
    input  logic        mem_access,
    input  logic        dmem_ack,
    output logic        dmem_req,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        ifid_flush,
    output logic        idex_flush,
`ifdef PIPE_CTRL_PERF_EN
    output logic [31:0] stall_cnt,
`endif
    output logic        bus_err
);

    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_ERR      = 2'd3
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       load_use;
    logic       run_rules;

    // Register 0 is hardwired, so a load targeting it can never feed ID.
    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((ex_rd == id_rs) || (ex_rd == id_rt));

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (((state_q == ST_RUN) || (state_q == ST_MEM_WAIT)) && !pc_en &&
            (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            wait_cnt_q <= 8'd0;
`ifdef PIPE_CTRL_PERF_EN
            stall_cnt_q <= 32'd0;
`endif
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
`ifdef PIPE_CTRL_PERF_EN
            stall_cnt_q <= stall_cnt_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_INIT: state_d = ST_RUN;
            ST_RUN: begin
                if (mem_access && !dmem_ack) begin
                    state_d    = ST_MEM_WAIT;
                    wait_cnt_d = 8'd0;
                end
            end
            ST_MEM_WAIT: begin
                // An ack in the last allowed cycle still completes normally.
                if (dmem_ack) begin
                    state_d = ST_RUN;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = ST_ERR;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_INIT;
        endcase
    end

    // Output logic
    always_comb begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_en    = 1'b0;
        exmem_en   = 1'b0;
        memwb_en   = 1'b0;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        dmem_req   = 1'b0;
        bus_err    = 1'b0;
        run_rules  = 1'b0;

        case (state_q)
            ST_INIT: begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end
            ST_RUN: begin
                dmem_req  = mem_access;
                run_rules = !(mem_access && !dmem_ack);
            end
            ST_MEM_WAIT: begin
                // The ack cycle is a normal issue cycle; the request is
                // still asserted so it covers the ack inclusively.
                dmem_req  = 1'b1;
                run_rules = dmem_ack;
            end
            ST_ERR: begin
                bus_err = 1'b1;
            end
            default: begin
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end
        endcase

        if (run_rules) begin
            if (branch_taken) begin
                // Squashing ID also removes any load-use dependant.
                pc_en      = 1'b1;
                ifid_en    = 1'b1;
                idex_en    = 1'b1;
                exmem_en   = 1'b1;
                memwb_en   = 1'b1;
                ifid_flush = 1'b1;
                idex_flush = 1'b1;
            end else if (load_use) begin
                idex_en    = 1'b1;
                exmem_en   = 1'b1;
                memwb_en   = 1'b1;
                idex_flush = 1'b1;
            end else begin
                pc_en      = 1'b1;
                ifid_en    = 1'b1;
                idex_en    = 1'b1;
                exmem_en   = 1'b1;
                memwb_en   = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

    localparam int TMO = 4;

    // Output vector bit order:
    // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, dmem_req, bus_err}
    localparam logic [8:0] O_INIT = 9'b00000_11_0_0;
    localparam logic [8:0] O_RUN  = 9'b11111_00_0_0;
    localparam logic [8:0] O_LU   = 9'b00111_01_0_0;
    localparam logic [8:0] O_BR   = 9'b11111_11_0_0;
    localparam logic [8:0] O_FRZ  = 9'b00000_00_1_0;
    localparam logic [8:0] O_ERR  = 9'b00000_00_0_1;

    localparam int M_INIT = 0, M_RUN = 1, M_WAIT = 2, M_ERR = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  id_rs, id_rt, ex_rd;
    logic        ex_mem_read, branch_taken, mem_access, dmem_ack;
    logic        dmem_req, pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_flush, bus_err;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] stall_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int          m_mode   = M_INIT;
    int          m_waited = 0;
    logic [31:0] m_stall  = 32'd0;

    pipeline_ctrl #(.TIMEOUT(TMO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .ex_rd        (ex_rd),
        .ex_mem_read  (ex_mem_read),
        .branch_taken (branch_taken),
        .mem_access   (mem_access),
        .dmem_ack     (dmem_ack),
        .dmem_req     (dmem_req),
        .pc_en        (pc_en),
        .ifid_en      (ifid_en),
        .idex_en      (idex_en),
        .exmem_en     (exmem_en),
        .memwb_en     (memwb_en),
        .ifid_flush   (ifid_flush),
        .idex_flush   (idex_flush),
`ifdef PIPE_CTRL_PERF_EN
        .stall_cnt    (stall_cnt),
`endif
        .bus_err      (bus_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [4:0] rs, rt, rd;
        logic       lr, br, ma, ack;
        logic [8:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [8:0] dut_out();
        return {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                ifid_flush, idex_flush, dmem_req, bus_err};
    endfunction

    // Behavioural view: what the pipeline should see given the mode we are in.
    function automatic logic [8:0] model_out();
        logic       hazard, normal, req;
        logic [8:0] o;
        hazard = ex_mem_read && ex_rd != 0 && (ex_rd == id_rs || ex_rd == id_rt);
        normal = 1'b0;
        req    = 1'b0;
        o      = '0;
        if (m_mode == M_INIT) return O_INIT;
        if (m_mode == M_ERR)  return O_ERR;
        if (m_mode == M_RUN) begin
            req    = mem_access;
            normal = !mem_access || dmem_ack;
        end else begin
            req    = 1'b1;
            normal = dmem_ack;
        end
        if (!normal)           o = O_FRZ;
        else if (branch_taken) o = O_BR;
        else if (hazard)       o = O_LU;
        else                   o = O_RUN;
        o[1] = req;
        return o;
    endfunction

    function automatic void model_step(input logic [8:0] o);
        if (!rst_n) begin
            m_mode = M_INIT; m_waited = 0; m_stall = 0;
            return;
        end
        if ((m_mode == M_RUN || m_mode == M_WAIT) && !o[8] && m_stall != 32'hFFFF_FFFF)
            m_stall = m_stall + 1;
        case (m_mode)
            M_INIT: m_mode = M_RUN;
            M_RUN:  if (mem_access && !dmem_ack) begin m_mode = M_WAIT; m_waited = 0; end
            M_WAIT: begin
                if (dmem_ack) m_mode = M_RUN;
                else begin
                    m_waited++;
                    if (m_waited == TMO) m_mode = M_ERR;
                end
            end
            default: ;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic apply(input logic rst, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic lr, input logic br,
                         input logic ma, input logic ack);
        @(negedge clk);
        rst_n = rst; id_rs = rs; id_rt = rt; ex_rd = rd;
        ex_mem_read = lr; branch_taken = br; mem_access = ma; dmem_ack = ack;
    endtask

    // Checks outputs against the model (or a fixed table value) and advances the model.
    task automatic sample(input string name, input bit use_tbl, input logic [8:0] tbl_exp,
                          output logic [8:0] act);
        logic [8:0] exp;
        #1;
        act = dut_out();
        exp = use_tbl ? tbl_exp : model_out();
        check(name, 32'(act), 32'(exp));
`ifdef PIPE_CTRL_PERF_EN
        check({name, "_stall_cnt"}, stall_cnt, m_stall);
`endif
        model_step(exp);
    endtask

    task automatic idle_cyc(input logic rst, input string name, output logic [8:0] act);
        apply(rst, 0, 0, 0, 0, 0, 0, 0);
        sample(name, 1'b0, '0, act);
    endtask

    task automatic mem_cyc(input logic rst, input logic ack, input string name,
                           input logic [8:0] exp, output logic [8:0] act);
        apply(rst, 0, 0, 0, 0, 0, 1, ack);
        sample(name, 1'b1, exp, act);
    endtask

    initial begin
        logic [8:0]  a;
        int          frz, req;
        logic [31:0] s0;
        rst_n = 1'b0; id_rs = 0; id_rt = 0; ex_rd = 0;
        ex_mem_read = 0; branch_taken = 0; mem_access = 0; dmem_ack = 0;

        vecs.push_back('{"default",       0, 0, 0, 0, 0, 0, 0, O_RUN});
        vecs.push_back('{"lu_rt",         3, 5, 5, 1, 0, 0, 0, O_LU});
        vecs.push_back('{"lu_rs",         7, 2, 7, 1, 0, 0, 0, O_LU});
        vecs.push_back('{"lu_rd0",        0, 0, 0, 1, 0, 0, 0, O_RUN});
        vecs.push_back('{"rd_match_noload", 5, 5, 5, 0, 0, 0, 0, O_RUN});
        vecs.push_back('{"load_nomatch",  6, 4, 5, 1, 0, 0, 0, O_RUN});
        vecs.push_back('{"branch_lu",     1, 5, 5, 1, 1, 0, 0, O_BR});
        vecs.push_back('{"branch",        0, 0, 0, 0, 1, 0, 0, O_BR});
        vecs.push_back('{"mem_ack0",      0, 0, 0, 0, 0, 1, 1, 9'b11111_00_1_0});
        vecs.push_back('{"mem_ack0_lu",   9, 9, 9, 1, 0, 1, 1, 9'b00111_01_1_0});
        vecs.push_back('{"mem_ack0_br",   9, 9, 9, 1, 1, 1, 1, 9'b11111_11_1_0});

        // Reset held 3 cycles, then one INIT cycle, then RUN.
        apply(0, 0, 0, 0, 0, 0, 0, 0); sample("reset1", 1, O_INIT, a);
        apply(0, 0, 0, 0, 0, 0, 0, 0); sample("reset2", 1, O_INIT, a);
        apply(1, 0, 0, 0, 0, 0, 0, 0); sample("init_after_release", 1, O_INIT, a);
        apply(1, 0, 0, 0, 0, 0, 0, 0); sample("run_after_init", 1, O_RUN, a);

        foreach (vecs[i]) begin
            apply(1, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].lr,
                  vecs[i].br, vecs[i].ma, vecs[i].ack);
            sample(vecs[i].name, 1, vecs[i].exp, a);
        end

        // Load-use then the load moves on: exactly one bubble.
        apply(1, 2, 5, 5, 1, 0, 0, 0); sample("lu_seq_stall", 1, O_LU, a);
        apply(1, 2, 5, 9, 0, 0, 0, 0); sample("lu_seq_resume", 1, O_RUN, a);

        // Ack three cycles after the request.
        frz = 0; req = 0;
`ifdef PIPE_CTRL_PERF_EN
        s0 = stall_cnt;
`else
        s0 = 0;
`endif
        mem_cyc(1, 0, "lat3_issue", O_FRZ, a);                   frz += int'(a[8:4] == 0); req += int'(a[1]);
        mem_cyc(1, 0, "lat3_w1",    O_FRZ, a);                   frz += int'(a[8:4] == 0); req += int'(a[1]);
        mem_cyc(1, 0, "lat3_w2",    O_FRZ, a);                   frz += int'(a[8:4] == 0); req += int'(a[1]);
        mem_cyc(1, 1, "lat3_ack",   9'b11111_00_1_0, a);         frz += int'(a[8:4] == 0); req += int'(a[1]);
        idle_cyc(1, "lat3_after", a);                            frz += int'(a[8:4] == 0); req += int'(a[1]);
        check("lat3_freeze_cycles", frz, 3);
        check("lat3_req_cycles", req, 4);
`ifdef PIPE_CTRL_PERF_EN
        check("lat3_stall_delta", stall_cnt - s0, 3);
`else
        s0 = s0 + 0;
`endif

        // Timeout: TMO unacked MEM_WAIT cycles trap to ERR.
        mem_cyc(1, 0, "tmo_issue", O_FRZ, a);
        for (int i = 0; i < TMO; i++) mem_cyc(1, 0, $sformatf("tmo_w%0d", i), O_FRZ, a);
        for (int i = 0; i < 3; i++) begin
            apply(1, 5, 5, 5, 1, 1, 1, 1);
            sample($sformatf("err_sticky%0d", i), 1, O_ERR, a);
        end
        apply(0, 0, 0, 0, 0, 0, 0, 0); sample("err_rst_cycle", 1, O_ERR, a);
        apply(1, 0, 0, 0, 0, 0, 1, 0); sample("err_cleared_init", 1, O_INIT, a);
        idle_cyc(1, "err_run", a);

        // Ack on the last allowed wait cycle wins over the timeout.
        mem_cyc(1, 0, "late_issue", O_FRZ, a);
        for (int i = 0; i < TMO - 1; i++) mem_cyc(1, 0, $sformatf("late_w%0d", i), O_FRZ, a);
        mem_cyc(1, 1, "late_ack", 9'b11111_00_1_0, a);
        apply(1, 0, 0, 0, 0, 0, 0, 0); sample("late_no_err", 1, O_RUN, a);

        // Reset in the middle of MEM_WAIT drops the request.
        mem_cyc(1, 0, "mid_issue", O_FRZ, a);
        mem_cyc(0, 0, "mid_rst_cycle", O_FRZ, a);
        mem_cyc(1, 0, "mid_init", O_INIT, a);
        idle_cyc(1, "mid_run", a);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            apply(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1,
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 9) < 3));
            sample("rand", 0, '0, a);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the five-stage pipeline. It drives the load enables and flush strobes of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It detects load-use hazards and squashes wrong-path instructions on taken branches. It also freezes the whole pipeline around a handshaked data-memory access, with a timeout that traps to an error state.

## Interface
- `TIMEOUT`, 255: maximum cycles spent in MEM_WAIT before trapping; legal range 2..255.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `id_rs`  in  5  source register 1 of the instruction in ID.
- `id_rt`  in  5  source register 2 of the instruction in ID.
- `ex_rd`  in  5  destination register of the instruction in EX.
- `ex_mem_read`  in  1  the instruction in EX is a load.
- `branch_taken`  in  1  branch resolved taken in EX this cycle.
- `mem_access`  in  1  the instruction in MEM performs a data-memory read or write.
- `dmem_ack`  in  1  data memory has completed the access this cycle.
- `dmem_req`  out  1  data-memory request.
- `pc_en`, `ifid_en`, `idex_en`, `exmem_en`, `memwb_en`  out  1 each  stage register load enables.
- `ifid_flush`, `idex_flush`  out  1 each  load a bubble (all-zero control) into the stage.
- `bus_err`  out  1  sticky memory-timeout error flag.

## Operation
- The FSM states are INIT, RUN, MEM_WAIT and ERR. A 8-bit `wait_cnt` is registered alongside.
- **INIT** is entered on reset and held for exactly one cycle after `rst_n` returns high, then the FSM goes to RUN.
  - All enables are 0, both flushes are 1, `dmem_req`=0, `bus_err`=0.
- **RUN**:
  - `dmem_req` = `mem_access`.
  - If `mem_access` && !`dmem_ack`: all five enables are 0, flushes are 0, `wait_cnt` is cleared, and next state is MEM_WAIT.
  - Otherwise the hazard rules below apply, in priority order.
- **Branch rule**: if `branch_taken`, all enables are 1, `ifid_flush`=1 and `idex_flush`=1.
  - This overrides load-use, because the dependent instruction is squashed.
- **Load-use rule**: if `ex_mem_read` && `ex_rd`≠0 && (`ex_rd`==`id_rs` || `ex_rd`==`id_rt`):
  - `pc_en`=0, `ifid_en`=0, `idex_flush`=1; `idex_en`, `exmem_en` and `memwb_en` are 1.
  - Exactly one bubble is inserted; the next cycle re-evaluates with the load in MEM.
- **Default**: all enables are 1 and both flushes are 0.
- **MEM_WAIT**:
  - `dmem_req`=1; all enables are 0 and flushes are 0; `branch_taken` and load-use are ignored.
  - On `dmem_ack`: that cycle uses the RUN rules (the branch, load-use and default rules; the memory freeze does not apply), and next state is RUN.
  - On no ack: if `wait_cnt`==TIMEOUT-1, next state is ERR; otherwise `wait_cnt`+1.
- **ERR**: all enables are 0, flushes are 0, `dmem_req`=0, `bus_err`=1. Only reset leaves ERR.
- A register address of 0 never creates a hazard.

## Timing
- All outputs are combinational from the registered state and current inputs; there are no registered outputs other than through state.
- Reset values (the cycle after `rst_n` is sampled low): state INIT, outputs as defined for INIT.
- Reset asserted mid-MEM_WAIT or in ERR goes to INIT on the next edge, drops `dmem_req`, and clears `bus_err`.
- Memory latency: ack in the same cycle as the first `dmem_req` gives 0 freeze cycles. Ack N cycles later gives N freeze cycles.
- Timeout: TIMEOUT consecutive MEM_WAIT cycles without ack lead to ERR on the following edge. An ack in the last MEM_WAIT cycle wins over the timeout.
- `dmem_req` stays high continuously from the RUN cycle of issue until the ack cycle inclusive. It never deasserts early.

## Configuration
- `PIPE_CTRL_PERF_EN`: when defined, adds output `stall_cnt` (32 bits).
  - It increments on every cycle in RUN or MEM_WAIT where `pc_en`=0.
  - It saturates at 0xFFFF_FFFF and clears on reset.
- Without the macro, the port and its counter do not exist and behaviour is otherwise identical.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles, then release → one INIT cycle with enables 0 and flushes 1; RUN thereafter with all enables 1.
- Load-use: `ex_mem_read`=1, `ex_rd`=5, `id_rt`=5 → exactly one cycle with `pc_en`=`ifid_en`=0 and `idex_flush`=1. Repeat with `ex_rd`=0 → no stall.
- Branch and load-use in the same cycle → `ifid_flush`=`idex_flush`=1, `pc_en`=1, no stall.
- Memory access with `dmem_ack` 3 cycles after the request → 3 cycles with all enables 0, `dmem_req` high for 4 cycles, and `stall_cnt`=3 when PERF is enabled.
- `TIMEOUT`=4, no ack → `bus_err`=1 after 4 MEM_WAIT cycles and stays set. Asserting `rst_n`=0 clears it. A second run with ack on the 4th wait cycle → returns to RUN with no error.
